// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that shares one APB master port among N_REQ requesters.
// It sequences the SETUP/ACCESS phases and returns the response to the granted requester.
module apb_master_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ-1:0]          req_write,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_slverr,
    output logic                      busy,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic                      PWRITE,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic                      PREADY,
    input  logic [DATA_W-1:0]         PRDATA,
    input  logic                      PSLVERR
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [IDX_W-1:0]       gidx_q, gidx_d;
    logic [ADDR_W-1:0]      paddr_q, paddr_d;
    logic                   pwrite_q, pwrite_d;
    logic [DATA_W-1:0]      pwdata_q, pwdata_d;
    logic                   psel_q, psel_d;
    logic                   penable_q, penable_d;
    logic [N_REQ-1:0]       rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_slverr_q, rsp_slverr_d;
    logic [N_REQ-1:0]       req_ready_c;
    logic                   gnt_found;
    logic [IDX_W-1:0]       gnt_idx;

    // (base + off) mod N_REQ, so non power-of-two N_REQ never reaches a missing index
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return IDX_W'(s);
    endfunction

    // First requesting index at or above the round-robin pointer, with wrap-around
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            if (!gnt_found && req_valid[wrap_idx(rr_q, off)]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap_idx(rr_q, off);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        gidx_d       = gidx_q;
        paddr_d      = paddr_q;
        pwrite_d     = pwrite_q;
        pwdata_d     = pwdata_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_slverr_d = rsp_slverr_q;
        req_ready_c  = '0;

        case (state_q)
            IDLE: begin
                // Suppressed during reset so no requester sees an accept that is then discarded
                if (gnt_found && !PRESET) begin
                    req_ready_c[gnt_idx] = 1'b1;
                    gidx_d   = gnt_idx;
                    paddr_d  = req_addr[32'(gnt_idx)*ADDR_W +: ADDR_W];
                    pwrite_d = req_write[gnt_idx];
                    pwdata_d = req_wdata[32'(gnt_idx)*DATA_W +: DATA_W];
                    rr_d     = (gnt_idx == IDX_W'(N_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    rsp_valid_d[gidx_q] = 1'b1;
                    rsp_rdata_d         = pwrite_q ? '0 : PRDATA;
                    rsp_slverr_d        = PSLVERR;
                    state_d             = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        psel_d    = (state_d != IDLE);
        penable_d = (state_d == ACCESS);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            gidx_q       <= '0;
            paddr_q      <= '0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            gidx_q       <= gidx_d;
            paddr_q      <= paddr_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_slverr_q <= rsp_slverr_d;
        end
    end

    assign req_ready  = req_ready_c;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_slverr = rsp_slverr_q;
    assign busy       = psel_q;
    assign PSEL       = psel_q;
    assign PENABLE    = penable_q;
    assign PADDR      = paddr_q;
    assign PWRITE     = pwrite_q;
    assign PWDATA     = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: directed transfers against a small APB slave,
// with a separate monitor matching every rsp_valid pulse against the expected queue.
module tb_apb_master_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_write;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_slverr;
    logic              busy;
    logic              PSEL;
    logic              PENABLE;
    logic [AW-1:0]     PADDR;
    logic              PWRITE;
    logic [DW-1:0]     PWDATA;
    logic              PREADY = 1'b0;
    logic [DW-1:0]     PRDATA;
    logic              PSLVERR;

    apb_master_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
        .busy(busy), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA),
        .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int gnt_cyc = 0;

    always @(posedge PCLK) cyc++;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sbq[$];

    // Slave model: PREADY rises after s_waits ACCESS cycles
    int          s_waits = 0;
    int          s_cnt   = 0;
    logic [31:0] s_rdata = '0;
    logic        s_err   = 1'b0;
    assign PRDATA  = s_rdata;
    assign PSLVERR = s_err;

    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            PREADY = (s_cnt >= s_waits);
            s_cnt++;
        end else begin
            PREADY = 1'b0;
            s_cnt  = 0;
        end
    end

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Monitor: every completion pulse must match the oldest expected response
    always @(negedge PCLK) begin
        exp_t e;
        if (rsp_valid !== '0) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: got rsp_valid=%b expected none (t=%0t)",
                         rsp_valid, $time);
            end else begin
                e = sbq.pop_front();
                chk("rsp_valid", 64'(rsp_valid), 64'(1) << e.idx);
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                chk("rsp_slverr", 64'(rsp_slverr), 64'(e.err));
            end
        end
    end

    // Called at a negedge; waits (bounded) for an accept, checks it, returns 1 after the edge
    task automatic wait_grant(input int idx, input string nm);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (req_ready !== '0) begin
                got = 1'b1;
                break;
            end
            @(negedge PCLK);
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no req_ready expected grant %0d", nm, idx);
        end else begin
            chk(nm, 64'(req_ready), 64'(1) << idx);
            gnt_cyc = cyc;
        end
        @(posedge PCLK);
        #1;
    endtask

    // Bounded wait for the transfer to finish; returns at the negedge of the response cycle
    task automatic wait_done(output int pen);
        pen = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge PCLK);
            if (!busy) break;
            if (PENABLE) pen++;
        end
    endtask

    task automatic do_xfer(input int idx, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int waits,
                           input logic [31:0] rdata, input logic err);
        int pen;
        exp_t e;
        s_waits = waits;
        s_rdata = rdata;
        s_err   = err;
        req_write[idx]        = wr;
        req_addr[idx*32 +: 32]  = addr;
        req_wdata[idx*32 +: 32] = wdata;
        req_valid[idx]        = 1'b1;
        e.idx   = idx;
        e.rdata = wr ? 32'h0 : rdata;
        e.err   = err;
        sbq.push_back(e);
        wait_grant(idx, "grant");
        req_valid[idx] = 1'b0;
        @(negedge PCLK);
        chk("setup_psel", 64'(PSEL), 64'(1));
        chk("setup_penable", 64'(PENABLE), 64'(0));
        chk("setup_paddr", 64'(PADDR), 64'(addr));
        chk("setup_pwrite", 64'(PWRITE), 64'(wr));
        if (wr) chk("setup_pwdata", 64'(PWDATA), 64'(wdata));
        wait_done(pen);
        chk("penable_cycles", 64'(pen), 64'(waits + 1));
        chk("hold_paddr", 64'(PADDR), 64'(addr));
        chk("hold_pwrite", 64'(PWRITE), 64'(wr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   pen;
        int   last;
        exp_t e;
        PRESET    = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(negedge PCLK);
        chk("rst_psel", 64'(PSEL), 64'(0));
        chk("rst_penable", 64'(PENABLE), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_paddr", 64'(PADDR), 64'(0));
        chk("rst_pwrite", 64'(PWRITE), 64'(0));
        chk("rst_pwdata", 64'(PWDATA), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("rst_rsp_slverr", 64'(rsp_slverr), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        PRESET = 1'b0;

        // 1: req0 read, zero wait states
        do_xfer(0, 1'b0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1'b0);
        // 2: req1 write, three wait states
        do_xfer(1, 1'b1, 32'h24, 32'hA5A5A5A5, 3, 32'h12345678, 1'b0);

        // 3: all requesters held high -> 0,1,2,3,0 every 3 cycles (pointer is 2 here, so reset it first)
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        s_waits = 0;
        s_rdata = 32'hCAFE0001;
        s_err   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_write[i]        = 1'b0;
            req_addr[i*32 +: 32] = 32'h100 + 32'(i * 4);
        end
        req_valid = 4'hF;
        last = 0;
        for (int k = 0; k < 5; k++) begin
            e.idx   = k % 4;
            e.rdata = 32'hCAFE0001;
            e.err   = 1'b0;
            sbq.push_back(e);
            wait_grant(k % 4, "rr_grant");
            if (k > 0) chk("rr_spacing", 64'(gnt_cyc - last), 64'(3));
            last = gnt_cyc;
            if (k == 4) req_valid = '0;
            wait_done(pen);
        end

        // 4: req3 read with slave error, then a clean transfer
        do_xfer(3, 1'b0, 32'h38, 32'h0, 0, 32'h0BADF00D, 1'b1);
        do_xfer(1, 1'b1, 32'h44, 32'h11223344, 1, 32'h55555555, 1'b0);

        // 5: reset while req2 is in ACCESS
        s_waits = 50;
        req_write[2]       = 1'b0;
        req_addr[64 +: 32] = 32'h30;
        req_valid[2]       = 1'b1;
        wait_grant(2, "grant_pre_reset");
        req_valid[2] = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        chk("pre_reset_penable", 64'(PENABLE), 64'(1));
        PRESET = 1'b1;
        @(posedge PCLK);
        #1;
        chk("abort_psel", 64'(PSEL), 64'(0));
        chk("abort_penable", 64'(PENABLE), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_rsp_valid", 64'(rsp_valid), 64'(0));
        @(negedge PCLK);
        PRESET = 1'b0;
        req_write[2]       = 1'b0;
        req_addr[64 +: 32] = 32'h34;
        req_valid[2]       = 1'b1;
        do_xfer(0, 1'b0, 32'h14, 32'h0, 0, 32'h00C0FFEE, 1'b0);
        do_xfer(2, 1'b0, 32'h34, 32'h0, 0, 32'h22222222, 1'b0);

        // 6: pointer now at 3; req0 and req3 together -> 3 first, then 0
        do_xfer(2, 1'b1, 32'h48, 32'h87654321, 0, 32'h0, 1'b0);
        req_write[0]      = 1'b0;
        req_addr[0 +: 32] = 32'h18;
        req_valid[0]      = 1'b1;
        do_xfer(3, 1'b0, 32'h3C, 32'h0, 2, 32'h33333333, 1'b0);
        do_xfer(0, 1'b0, 32'h18, 32'h0, 0, 32'h44444444, 1'b0);

        repeat (4) @(negedge PCLK);
        chk("scoreboard_empty", 64'(sbq.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
